axi_grid_aw_w_coupler: RTL and testbench

- Upstream stage of the grid network interface: takes a master's raw AXI AW and W channels and produces grid-tagged AW and W flits for the NI to inject.
- Tags each flit with destination NI ID (decoded from address) and source NI ID.
- Guarantees no W beat is issued before its AW, and regenerates W last from the burst length.
- Holds a small queue of outstanding write bursts.

---
 rtl/axi_grid_pkg.sv | 60 ++++++
 rtl/axi_grid_fifo.sv | 59 +++++
 rtl/axi_grid_aw_w_coupler.sv | 195 +++++++++++++++++++
 tb/tb_axi_grid_aw_w_coupler.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_grid_pkg.sv
// axi_grid_pkg: shared types and default widths for the grid AW/W coupler.
// Holds the raw AXI AW/W payloads, the grid-tagged flit payloads, the
// burst-info queue entry, and the W-path FSM state encoding.
package axi_grid_pkg;

    localparam int DEF_GRID_ID_WIDTH   = 4;
    localparam int DEF_AXI_ID_WIDTH    = 4;
    localparam int DEF_ADDR_WIDTH      = 32;
    localparam int DEF_DATA_WIDTH      = 64;
    localparam int DEF_STRB_WIDTH      = DEF_DATA_WIDTH / 8;
    localparam int DEF_DEST_LSB        = 28;
    localparam int DEF_MAX_OUTSTANDING = 4;

    typedef logic [DEF_GRID_ID_WIDTH-1:0] grid_id_t;

    typedef struct packed {
        grid_id_t dest;
        grid_id_t src;
    } grid_hdr_t;

    typedef struct packed {
        logic [DEF_AXI_ID_WIDTH-1:0] id;
        logic [DEF_ADDR_WIDTH-1:0]   addr;
        logic [7:0]                  len;
        logic [2:0]                  size;
        logic [1:0]                  burst;
    } aw_chan_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_STRB_WIDTH-1:0] strb;
        logic                      last;
    } w_chan_t;

    typedef struct packed {
        grid_id_t dest;
        grid_id_t src;
        aw_chan_t aw;
    } grid_aw_chan_t;

    typedef struct packed {
        grid_id_t                  dest;
        grid_id_t                  src;
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_STRB_WIDTH-1:0] strb;
        logic                      last;
    } grid_w_chan_t;

    // One entry per accepted AW: where its W beats go and how many there are.
    typedef struct packed {
        grid_id_t   dest;
        logic [7:0] len;
    } burst_info_t;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_e;

endpackage

// File: rtl/axi_grid_fifo.sv
// axi_grid_fifo: small synchronous FIFO with first-word-fall-through head.
// Ports:
//   clk_i, arst_i       clock, asynchronous active-high reset
//   push_i, data_i      write an entry (ignored when full)
//   pop_i               drop the head entry (ignored when empty)
//   full_o, empty_o     occupancy flags
//   head_o              oldest entry, valid while !empty_o
// DEPTH must be a power of two, 2 or more. A pushed entry becomes visible
// on head_o the cycle after the push; full/empty have no same-cycle bypass.
module axi_grid_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output T     head_o
);

    localparam int PW = $clog2(DEPTH);

    T             mem_q [DEPTH];
    logic [PW:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/axi_grid_aw_w_coupler.sv
// axi_grid_aw_w_coupler: turns a master's raw AXI AW/W channels into
// grid-tagged AW and W flits. Every flit carries {dest, src}; dest is taken
// from aw.addr[DEST_LSB +: GRID_ID_WIDTH], src is NI_ID. A W beat is only
// accepted once its AW has been queued, and W last is regenerated from the
// burst length rather than trusted from the master.
// Ports:
//   clk_i, arst_i                        clock, asynchronous active-high reset
//   aw_i, aw_valid_i, aw_ready_o         raw AXI AW
//   w_i,  w_valid_i,  w_ready_o          raw AXI W
//   grid_aw_o, grid_aw_valid_o, grid_aw_ready_i   tagged AW flit
//   grid_w_o,  grid_w_valid_o,  grid_w_ready_i    tagged W flit
//   err_wlast_o                          sticky "master's W last disagreed"
// Handshakes: a transfer happens on a rising edge where valid && ready;
// valid never waits on ready, and payload is held while valid && !ready.
// Build option: define AXI_GRID_WLAST_CHECK_EN to build the W-last mismatch
// detector; otherwise err_wlast_o is tied to 0.
// Width parameters must match the axi_grid_pkg defaults used for the types.
module axi_grid_aw_w_coupler
    import axi_grid_pkg::*;
#(
    parameter int NI_ID           = 0,
    parameter int GRID_ID_WIDTH   = DEF_GRID_ID_WIDTH,
    parameter int AXI_ID_WIDTH    = DEF_AXI_ID_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int DEST_LSB        = DEF_DEST_LSB,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  aw_chan_t      aw_i,
    input  logic          aw_valid_i,
    output logic          aw_ready_o,
    input  w_chan_t       w_i,
    input  logic          w_valid_i,
    output logic          w_ready_o,
    output grid_aw_chan_t grid_aw_o,
    output logic          grid_aw_valid_o,
    input  logic          grid_aw_ready_i,
    output grid_w_chan_t  grid_w_o,
    output logic          grid_w_valid_o,
    input  logic          grid_w_ready_i,
    output logic          err_wlast_o
);

    localparam grid_id_t SRC_ID = grid_id_t'(NI_ID);

    // Typed views of the incoming payload fields at the configured widths.
    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0]     aw_addr;
    logic [DATA_WIDTH-1:0]     w_data;
    logic [DATA_WIDTH/8-1:0]   w_strb;
    grid_id_t                  aw_dest;

    assign aw_id   = aw_i.id;
    assign aw_addr = aw_i.addr;
    assign w_data  = w_i.data;
    assign w_strb  = w_i.strb;
    assign aw_dest = aw_addr[DEST_LSB +: GRID_ID_WIDTH];

    // Burst-info queue
    logic        q_push, q_pop, q_full, q_empty;
    burst_info_t q_in, q_head;

    axi_grid_fifo #(
        .T     (burst_info_t),
        .DEPTH (MAX_OUTSTANDING)
    ) u_burst_q (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .push_i  (q_push),
        .data_i  (q_in),
        .pop_i   (q_pop),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (q_head)
    );

    // State
    grid_aw_chan_t grid_aw_q, grid_aw_d;
    logic          grid_aw_valid_q, grid_aw_valid_d;
    grid_w_chan_t  grid_w_q, grid_w_d;
    logic          grid_w_valid_q, grid_w_valid_d;
    w_state_e      state_q, state_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic          beat_last;
    logic          aw_hs, w_hs;

    assign aw_ready_o = (!grid_aw_valid_q || grid_aw_ready_i) && !q_full;
    assign aw_hs      = aw_valid_i && aw_ready_o;
    assign w_ready_o  = !q_empty && (!grid_w_valid_q || grid_w_ready_i);
    assign w_hs       = w_valid_i && w_ready_o;

    assign q_push = aw_hs;
    assign q_in   = '{dest: aw_dest, len: aw_i.len};
    assign q_pop  = w_hs && beat_last;

    // W beat tracking. beat_cnt_q holds the index of the previous beat, so in
    // BURST the current beat is beat_cnt_q+1; it never exceeds 255 for len 255.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        beat_last  = 1'b0;
        case (state_q)
            W_IDLE: begin
                beat_last = (q_head.len == 8'd0);
                if (w_hs) begin
                    beat_cnt_d = 8'd0;
                    if (!beat_last) state_d = W_BURST;
                end
            end
            W_BURST: begin
                beat_last = ((beat_cnt_q + 8'd1) == q_head.len);
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (beat_last) state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    // Output registers: load on handshake, clear valid when consumed.
    always_comb begin
        grid_aw_d       = grid_aw_q;
        grid_aw_valid_d = grid_aw_valid_q;
        if (aw_hs) begin
            grid_aw_valid_d  = 1'b1;
            grid_aw_d.dest   = aw_dest;
            grid_aw_d.src    = SRC_ID;
            grid_aw_d.aw     = aw_i;
            grid_aw_d.aw.id  = aw_id;
        end else if (grid_aw_ready_i) begin
            grid_aw_valid_d = 1'b0;
        end
    end

    always_comb begin
        grid_w_d       = grid_w_q;
        grid_w_valid_d = grid_w_valid_q;
        if (w_hs) begin
            grid_w_valid_d = 1'b1;
            grid_w_d.dest  = q_head.dest;
            grid_w_d.src   = SRC_ID;
            grid_w_d.data  = w_data;
            grid_w_d.strb  = w_strb;
            grid_w_d.last  = beat_last;
        end else if (grid_w_ready_i) begin
            grid_w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            grid_aw_q       <= '0;
            grid_aw_valid_q <= 1'b0;
            grid_w_q        <= '0;
            grid_w_valid_q  <= 1'b0;
            state_q         <= W_IDLE;
            beat_cnt_q      <= 8'd0;
        end else begin
            grid_aw_q       <= grid_aw_d;
            grid_aw_valid_q <= grid_aw_valid_d;
            grid_w_q        <= grid_w_d;
            grid_w_valid_q  <= grid_w_valid_d;
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
        end
    end

    assign grid_aw_o       = grid_aw_q;
    assign grid_aw_valid_o = grid_aw_valid_q;
    assign grid_w_o        = grid_w_q;
    assign grid_w_valid_o  = grid_w_valid_q;

`ifdef AXI_GRID_WLAST_CHECK_EN
    // Sticky: any accepted beat whose master-supplied last disagrees with
    // the length-derived last. The beat itself is forwarded unchanged.
    logic err_q, err_d;

    assign err_d = err_q | (w_hs && (w_i.last != beat_last));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_wlast_o = err_q;
`else
    logic unused_wlast;
    assign unused_wlast = w_i.last;
    assign err_wlast_o  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_grid_aw_w_coupler.sv
module tb_axi_grid_aw_w_coupler;
  import axi_grid_pkg::*;

  localparam int NI       = 5;
  localparam int DLSB     = 28;
  localparam int MAXO     = 4;
  localparam int AWB      = $bits(grid_aw_chan_t);
  localparam int WB       = $bits(grid_w_chan_t);
`ifdef AXI_GRID_WLAST_CHECK_EN
  localparam bit ERR_BUILT = 1'b1;
`else
  localparam bit ERR_BUILT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_i;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aw_chan_t      aw_i;
  logic          aw_valid_i, aw_ready_o;
  w_chan_t       w_i;
  logic          w_valid_i, w_ready_o;
  grid_aw_chan_t grid_aw_o;
  logic          grid_aw_valid_o, grid_aw_ready_i;
  grid_w_chan_t  grid_w_o;
  logic          grid_w_valid_o, grid_w_ready_i;
  logic          err_wlast_o;

  axi_grid_aw_w_coupler #(.NI_ID(NI)) dut (
    .clk_i           (clk),
    .arst_i          (arst_i),
    .aw_i            (aw_i),
    .aw_valid_i      (aw_valid_i),
    .aw_ready_o      (aw_ready_o),
    .w_i             (w_i),
    .w_valid_i       (w_valid_i),
    .w_ready_o       (w_ready_o),
    .grid_aw_o       (grid_aw_o),
    .grid_aw_valid_o (grid_aw_valid_o),
    .grid_aw_ready_i (grid_aw_ready_i),
    .grid_w_o        (grid_w_o),
    .grid_w_valid_o  (grid_w_valid_o),
    .grid_w_ready_i  (grid_w_ready_i),
    .err_wlast_o     (err_wlast_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [AWB-1:0] exp_aw_q[$];
  logic [WB-1:0]  exp_w_q[$];
  int             mq_dest[$];
  int             mq_len[$];
  int             beat_idx = 0;
  bit             model_err = 1'b0;

  always @(negedge clk) begin : monitor
    grid_aw_chan_t ea;
    grid_w_chan_t  ew;
    bit            exp_aw_rdy, exp_w_rdy, lst;
    if (arst_i) begin
      exp_aw_q.delete();
      exp_w_q.delete();
      mq_dest.delete();
      mq_len.delete();
      beat_idx  = 0;
      model_err = 1'b0;
      chk("rst_grid_aw_valid", 128'(grid_aw_valid_o), 128'(0));
      chk("rst_grid_w_valid", 128'(grid_w_valid_o), 128'(0));
      chk("rst_err", 128'(err_wlast_o), 128'(0));
    end else begin
      exp_aw_rdy = (mq_len.size() < MAXO) && (exp_aw_q.size() == 0 || grid_aw_ready_i);
      exp_w_rdy  = (mq_len.size() > 0) && (exp_w_q.size() == 0 || grid_w_ready_i);

      chk("grid_aw_valid", 128'(grid_aw_valid_o), 128'(exp_aw_q.size() != 0));
      if (grid_aw_valid_o && exp_aw_q.size() != 0) begin
        chk("grid_aw_payload", 128'(grid_aw_o), 128'(exp_aw_q[0]));
        if (grid_aw_ready_i) void'(exp_aw_q.pop_front());
      end
      chk("grid_w_valid", 128'(grid_w_valid_o), 128'(exp_w_q.size() != 0));
      if (grid_w_valid_o && exp_w_q.size() != 0) begin
        chk("grid_w_payload", 128'(grid_w_o), 128'(exp_w_q[0]));
        if (grid_w_ready_i) void'(exp_w_q.pop_front());
      end

      chk("aw_ready", 128'(aw_ready_o), 128'(exp_aw_rdy));
      chk("w_ready", 128'(w_ready_o), 128'(exp_w_rdy));
      chk("err_wlast", 128'(err_wlast_o), 128'(model_err && ERR_BUILT));

      // W accepted at the coming edge: belongs to the oldest open burst.
      if (w_valid_i && exp_w_rdy) begin
        lst     = (beat_idx == mq_len[0]);
        ew.dest = grid_id_t'(mq_dest[0]);
        ew.src  = grid_id_t'(NI);
        ew.data = w_i.data;
        ew.strb = w_i.strb;
        ew.last = lst;
        exp_w_q.push_back(ew);
        if (w_i.last != lst) model_err = 1'b1;
        if (lst) begin
          void'(mq_dest.pop_front());
          void'(mq_len.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
      if (aw_valid_i && exp_aw_rdy) begin
        ea.dest = grid_id_t'((aw_i.addr / (64'd1 << DLSB)) % 16);
        ea.src  = grid_id_t'(NI);
        ea.aw   = aw_i;
        exp_aw_q.push_back(ea);
        mq_dest.push_back(int'(ea.dest));
        mq_len.push_back(int'(aw_i.len));
      end
    end
  end

  // ---------------- downstream ready generator ----------------
  int rdy_mode = 0;
  initial begin
    grid_aw_ready_i = 1'b1;
    grid_w_ready_i  = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: begin grid_aw_ready_i = 1'b1; grid_w_ready_i = 1'b1; end
        1: begin grid_aw_ready_i = 1'b1; grid_w_ready_i = !grid_w_ready_i; end
        default: begin
          grid_aw_ready_i = 1'($urandom_range(0, 1));
          grid_w_ready_i  = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // ---------------- driver tasks (entered/left at posedge+1) ----------------
  task automatic set_aw(input logic [31:0] addr, input logic [7:0] len);
    aw_chan_t a;
    a.id    = 4'($urandom);
    a.addr  = addr;
    a.len   = len;
    a.size  = 3'($urandom);
    a.burst = 2'($urandom);
    aw_i    = a;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [7:0] len, input int gap,
                         output int edge_n);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    set_aw(addr, len);
    aw_valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (aw_ready_o) break;
      n++;
      if (n >= 300) begin chk("aw_timeout", 128'(aw_ready_o), 128'(1)); break; end
    end
    @(posedge clk); #1;
    edge_n     = cyc;
    aw_valid_i = 1'b0;
  endtask

  task automatic send_w(input logic last, input int gap);
    int n;
    repeat (gap) begin @(posedge clk); #1; end
    w_i.data   = {$urandom, $urandom};
    w_i.strb   = 8'($urandom);
    w_i.last   = last;
    w_valid_i  = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (w_ready_o) break;
      n++;
      if (n >= 300) begin chk("w_timeout", 128'(w_ready_o), 128'(1)); break; end
    end
    @(posedge clk); #1;
    w_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_aw_q.size() == 0 && exp_w_q.size() == 0 && mq_len.size() == 0) break;
      n++;
      if (n >= 500) begin
        chk("idle_timeout_open_bursts", 128'(mq_len.size()), 128'(0));
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e, aw_edge, gw_cyc, n;
    arst_i     = 1'b1;
    aw_i       = '0;
    w_i        = '0;
    aw_valid_i = 1'b0;
    w_valid_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_w_ready", 128'(w_ready_o), 128'(0));
    chk("reset_aw_ready", 128'(aw_ready_o), 128'(1));
    @(posedge clk); #1;
    arst_i = 1'b0;

    // Single burst, len 3, dest 3
    send_aw(32'h3000_0000, 8'd3, 0, e);
    @(negedge clk);
    chk("s1_aw_valid", 128'(grid_aw_valid_o), 128'(1));
    chk("s1_aw_dest", 128'(grid_aw_o.dest), 128'(3));
    chk("s1_aw_src", 128'(grid_aw_o.src), 128'(NI));
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) send_w(b == 3, 0);
    wait_idle();
    chk("s1_err", 128'(err_wlast_o), 128'(0));

    // W held before AW arrives
    fork
      begin
        repeat (5) begin @(posedge clk); #1; end
        send_aw(32'h1000_0000, 8'd0, 0, aw_edge);
      end
      send_w(1'b1, 0);
      begin
        n = 0;
        while (!grid_w_valid_o && n < 100) begin @(negedge clk); n++; end
        gw_cyc = cyc;
      end
    join
    chk("s3_first_w_latency", 128'(gw_cyc), 128'(aw_edge + 1));
    wait_idle();

    // Queue full with len-0 bursts, no W
    for (int i = 0; i < 4; i++) send_aw(32'h4000_0000 + 32'(i * 16), 8'd0, 0, e);
    set_aw(32'h5000_0000, 8'd0);
    aw_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("s4_full_ready", 128'(aw_ready_o), 128'(0));
    end
    @(posedge clk); #1;
    send_w(1'b1, 0);
    @(negedge clk);
    chk("s4_fifth_ready", 128'(aw_ready_o), 128'(1));
    @(posedge clk); #1;
    aw_valid_i = 1'b0;
    repeat (4) send_w(1'b1, 0);
    wait_idle();

    // Backpressure on a 16-beat burst
    rdy_mode = 1;
    send_aw(32'hA000_0100, 8'd15, 0, e);
    for (int b = 0; b < 16; b++) send_w(b == 15, 0);
    wait_idle();
    rdy_mode = 0;

    // Early last from master
    send_aw(32'h6000_0000, 8'd1, 0, e);
    send_w(1'b1, 0);
    send_w(1'b1, 0);
    wait_idle();
    @(negedge clk);
    chk("s6_err_set", 128'(err_wlast_o), 128'(ERR_BUILT));
    repeat (4) @(negedge clk);
    chk("s6_err_sticky", 128'(err_wlast_o), 128'(ERR_BUILT));
    @(posedge clk); #1;

    // Randomized traffic with random gaps and downstream stalls
    rdy_mode = 2;
    begin
      logic [31:0] addrs[24];
      logic [7:0]  lens[24];
      for (int i = 0; i < 24; i++) begin
        addrs[i] = $urandom;
        lens[i]  = 8'($urandom_range(0, 7));
      end
      fork
        begin
          int ee;
          for (int i = 0; i < 24; i++) send_aw(addrs[i], lens[i], $urandom_range(0, 2), ee);
        end
        begin
          logic lst;
          for (int i = 0; i < 24; i++) begin
            for (int b = 0; b <= int'(lens[i]); b++) begin
              lst = (b == int'(lens[i]));
              if ($urandom_range(0, 7) == 0) lst = !lst;
              send_w(lst, $urandom_range(0, 2));
            end
          end
        end
      join
    end
    wait_idle();
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset in the middle of a len-7 burst
    send_aw(32'h7000_0000, 8'd7, 0, e);
    send_w(1'b0, 0);
    w_i.data  = {$urandom, $urandom};
    w_i.strb  = 8'hFF;
    w_i.last  = 1'b0;
    w_valid_i = 1'b1;
    @(negedge clk);
    chk("s8_beat2_ready", 128'(w_ready_o), 128'(1));
    @(posedge clk); #1;
    arst_i    = 1'b1;
    w_valid_i = 1'b0;
    #1;
    chk("s8_rst_aw_valid", 128'(grid_aw_valid_o), 128'(0));
    chk("s8_rst_w_valid", 128'(grid_w_valid_o), 128'(0));
    chk("s8_rst_err", 128'(err_wlast_o), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    arst_i = 1'b0;
    send_aw(32'h2000_0040, 8'd0, 0, e);
    send_w(1'b1, 0);
    wait_idle();
    chk("end_err", 128'(err_wlast_o), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule
